// File: rtl/data_mem_ctrl.sv
// Byte-addressed data memory: masked stores, sign/zero-extending loads, alignment checking,
// and a post-reset zero-fill sequencer. Every accepted request answers READ_LAT cycles later.
module data_mem_ctrl #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int READ_LAT = 1,
  parameter int ADDR_W   = $clog2(DEPTH * DATA_W / 8)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              init_done
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [1:0]       MAX_SIZE = (DATA_W == 64) ? 2'd3 : 2'd2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t            r_state;
  logic [IDX_W-1:0]  r_initIdx;
  logic              r_ready;
  logic              r_initDone;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_s1Valid;
  logic              r_s1Error;
  logic [DATA_W-1:0] r_s1Data;

  logic              w_accept;
  logic              w_initWrite;
  logic              w_store;
  logic              w_legal;
  logic              w_sign;
  logic [OFF_W-1:0]  w_off;
  logic [OFF_W-1:0]  w_alignMask;
  logic [IDX_W-1:0]  w_idx;
  logic [3:0]        w_nBytes;
  logic [BYTES-1:0]  w_laneMask;
  logic [DATA_W-1:0] w_wdataShift;
  logic [DATA_W-1:0] w_rdWord;
  logic [DATA_W-1:0] w_shifted;
  logic [DATA_W-1:0] w_loadData;

  assign w_off        = req_addr[OFF_W-1:0];
  assign w_idx        = req_addr[ADDR_W-1:OFF_W];
  assign w_accept     = req_valid && r_ready && !reset;
  assign w_initWrite  = (r_state == S_INIT) && !reset;
  assign w_store      = w_accept && req_write && w_legal;
  assign w_wdataShift = req_wdata << {w_off, 3'b000};
  assign w_rdWord     = r_mem[w_idx];
  assign w_shifted    = w_rdWord >> {w_off, 3'b000};

  // Access size decode: legality (size fits the word, address aligned to size) and lane mask.
  always_comb begin
    w_nBytes = 4'd1;
    case (req_size)
      2'd0:    w_nBytes = 4'd1;
      2'd1:    w_nBytes = 4'd2;
      2'd2:    w_nBytes = 4'd4;
      default: w_nBytes = 4'd8;
    endcase
    w_alignMask = '0;
    for (int b = 0; b < OFF_W; b++) w_alignMask[b] = (b < int'(req_size));
    w_legal = (req_size <= MAX_SIZE) && ((w_off & w_alignMask) == '0);
    w_laneMask = '0;
    for (int b = 0; b < BYTES; b++) w_laneMask[b] = (b < int'(w_nBytes));
    w_laneMask = w_laneMask << w_off;
  end

  // Bytes above the access size are filled with the sign bit, or with zero for unsigned loads.
  always_comb begin
    w_sign = 1'b0;
    case (req_size)
      2'd0:    w_sign = w_shifted[7];
      2'd1:    w_sign = w_shifted[15];
      2'd2:    w_sign = w_shifted[31];
      default: w_sign = w_shifted[DATA_W-1];
    endcase
    w_sign = w_sign && !req_unsigned;
    w_loadData = w_shifted;
    for (int b = 0; b < BYTES; b++)
      if (b >= int'(w_nBytes)) w_loadData[8*b +: 8] = {8{w_sign}};
  end

  always_ff @(posedge clk) begin
    if (w_initWrite) begin
      r_mem[r_initIdx] <= '0;
    end else if (w_store) begin
      for (int b = 0; b < BYTES; b++)
        if (w_laneMask[b]) r_mem[w_idx][8*b +: 8] <= w_wdataShift[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_INIT;
      r_initIdx  <= '0;
      r_ready    <= 1'b0;
      r_initDone <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_initIdx <= r_initIdx + 1'b1;
          if (r_initIdx == LAST_IDX) begin
            r_state    <= S_READY;
            r_ready    <= 1'b1;
            r_initDone <= 1'b1;
          end
        end
        default: begin
          r_ready    <= 1'b1;
          r_initDone <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1Valid <= 1'b0;
      r_s1Error <= 1'b0;
      r_s1Data  <= '0;
    end else begin
      r_s1Valid <= w_accept;
      r_s1Error <= w_accept && !w_legal;
      r_s1Data  <= (w_accept && !req_write && w_legal) ? w_loadData : '0;
    end
  end

  // The second latency stage is a plain retiming register after the extend logic.
  if (READ_LAT == 2) begin : g_lat2
    logic              r_s2Valid;
    logic              r_s2Error;
    logic [DATA_W-1:0] r_s2Data;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_s2Valid <= 1'b0;
        r_s2Error <= 1'b0;
        r_s2Data  <= '0;
      end else begin
        r_s2Valid <= r_s1Valid;
        r_s2Error <= r_s1Error;
        r_s2Data  <= r_s1Data;
      end
    end

    assign rsp_valid = r_s2Valid;
    assign rsp_error = r_s2Error;
    assign rsp_rdata = r_s2Data;
  end else begin : g_lat1
    assign rsp_valid = r_s1Valid;
    assign rsp_error = r_s1Error;
    assign rsp_rdata = r_s1Data;
  end

  assign req_ready = r_ready;
  assign init_done = r_initDone;

endmodule
